// File: rtl/qbus_mem_slave.sv
// qbus_mem_slave: Q-bus responder memory.
// Serves DATI / DATO(B) / DATIO(B) cycles on the multiplexed ad[15:0] bus.
// It decodes a window of 2^AW words at BASE and replies with rply_n.
// Optional feature macro: QMEM_WPROT_EN adds a wprot input. When wprot is
// high, writes are dropped but the cycle is still acknowledged.
module qbus_mem_slave #(
    parameter int          AW       = 10,
    parameter logic [15:0] BASE     = 16'h0000,
    parameter int          RPLY_DLY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_n,
    input  logic       sync_n,
    input  logic       din_n,
    input  logic       dout_n,
    input  logic       wtbt_n,
    inout  wire [15:0] ad,
    output logic       rply_n,
`ifdef QMEM_WPROT_EN
    output logic       sel,
    input  logic       wprot
`else
    output logic       sel
`endif
);

    typedef enum logic [2:0] {
        IDLE, MISS, ADDR, RWAIT, WWAIT, RDRV, WDO, WHOLD
    } state_t;

    state_t          state, next;
    logic            sync_q;
    logic [AW:0]     a;
    logic [3:0]      cnt;
    logic [15:0]     ad_q;
    logic            ad_oe;
    logic            rply_d, oe_d, sel_d;
    logic [15:0]     mem [0:(2**AW)-1];

    // INIT behaves exactly like reset for the bus cycle, but it leaves the
    // synchroniser and the RAM alone.
    wire abort     = reset | ~init_n;
    wire sync_fall = ~sync_n & sync_q;
    wire hit       = (ad[15:AW+1] == BASE[15:AW+1]);
    wire wr_en     =
`ifdef QMEM_WPROT_EN
        ~wprot;
`else
        1'b1;
`endif

    // The bus pin is driven only while a read is being answered.
    assign ad = ad_oe ? ad_q : 16'hzzzz;

    // State register
    always_ff @(posedge clk) begin
        if (abort) state <= IDLE;
        else       state <= next;
    end

    // Next-state logic. A released sync_n ends any cycle, wherever it is.
    always_comb begin
        next = state;
        case (state)
            IDLE:  if (sync_fall) next = hit ? ADDR : MISS;
            MISS:  next = MISS;
            ADDR: begin
                if (!din_n && dout_n)      next = RWAIT;
                else if (!dout_n && din_n) next = WWAIT;
            end
            RWAIT: if (cnt == 4'd0) next = RDRV;
            WWAIT: if (cnt == 4'd0) next = WDO;
            RDRV:  if (din_n) next = ADDR;
            WDO:   next = WHOLD;
            WHOLD: if (dout_n) next = ADDR;
            default: next = IDLE;
        endcase
        if (state != IDLE && sync_n) next = IDLE;
    end

    // Output decode from the next state, so the registered outputs change on
    // the same edge as the state.
    always_comb begin
        rply_d = ~(next == RDRV || next == WDO || next == WHOLD);
        oe_d   = (next == RDRV);
        sel_d  = ~(next == IDLE || next == MISS);
    end

    // Registered bus outputs
    always_ff @(posedge clk) begin
        if (abort) begin
            rply_n <= 1'b1;
            ad_oe  <= 1'b0;
            sel    <= 1'b0;
        end else begin
            rply_n <= rply_d;
            ad_oe  <= oe_d;
            sel    <= sel_d;
        end
    end

    // Edge detector, address latch and reply-delay counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 1'b1;
            a      <= '0;
            cnt    <= 4'd0;
        end else begin
            sync_q <= sync_n;
            if (state == IDLE && sync_fall)
                a <= ad[AW:0];
            if (state == ADDR)
                cnt <= 4'(RPLY_DLY);
            else if ((state == RWAIT || state == WWAIT) && cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end

    // RAM: no reset. A write commits only when WDO really advances, which
    // excludes an aborted cycle. Read data is captured on entry to RDRV.
    always_ff @(posedge clk) begin
        if (state == WDO && next == WHOLD && !abort && wr_en) begin
            if (wtbt_n)    mem[a[AW:1]]       <= ad;
            else if (a[0]) mem[a[AW:1]][15:8] <= ad[7:0];
            else           mem[a[AW:1]][7:0]  <= ad[7:0];
        end
        if (next == RDRV && state != RDRV)
            ad_q <= mem[a[AW:1]];
    end

endmodule

// File: tb/tb_qbus_mem_slave.sv
// tb_qbus_mem_slave: directed bench for qbus_mem_slave (AW=10, BASE=0, RPLY_DLY=1).
// When the DUT should not be driving, the bench holds ad at 0. Any DUT drive
// then shows up as a non-zero value on the resolved net.
module tb_qbus_mem_slave;

    logic        clk = 1'b0;
    logic        reset, init_n, sync_n, din_n, dout_n, wtbt_n;
    logic        rply_n, sel;
    logic [15:0] tb_ad;
    logic        tb_oe;
    wire  [15:0] ad;
`ifdef QMEM_WPROT_EN
    logic        wprot = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    assign ad = tb_oe ? tb_ad : 16'hzzzz;

    always #5 clk = ~clk;

    qbus_mem_slave #(.AW(10), .BASE(16'h0000), .RPLY_DLY(1)) dut (
        .clk    (clk),
        .reset  (reset),
        .init_n (init_n),
        .sync_n (sync_n),
        .din_n  (din_n),
        .dout_n (dout_n),
        .wtbt_n (wtbt_n),
        .ad     (ad),
        .rply_n (rply_n),
`ifdef QMEM_WPROT_EN
        .sel    (sel),
        .wprot  (wprot)
`else
        .sel    (sel)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Address phase: the address is latched on the first edge that sees sync_n low.
    task automatic bus_start(input logic [15:0] addr);
        tb_oe  = 1'b1;
        tb_ad  = addr;
        sync_n = 1'b0;
        tick;
    endtask

    task automatic bus_end(input string tag);
        sync_n = 1'b1;
        tb_oe  = 1'b1;
        tb_ad  = 16'h0000;
        tick;
        chk({tag, "_sel_idle"}, 16'(sel), 16'h0000);
    endtask

    // Strobe sampled at edge N, so rply_n must be low after edge N+2 and not before.
    task automatic do_read(input string tag, input logic [15:0] exp);
        tb_oe = 1'b0;
        din_n = 1'b0;
        tick;
        tick;
        chk({tag, "_rply_early"}, 16'(rply_n), 16'h0001);
        tick;
        chk({tag, "_rply"}, 16'(rply_n), 16'h0000);
        chk({tag, "_data"}, ad, exp);
        din_n = 1'b1;
        tb_oe = 1'b1;
        tb_ad = 16'h0000;
        tick;
        chk({tag, "_rply_off"}, 16'(rply_n), 16'h0001);
        chk({tag, "_ad_rel"}, ad, 16'h0000);
    endtask

    task automatic do_write(input string tag, input logic [15:0] data, input logic wt);
        tb_oe  = 1'b1;
        tb_ad  = data;
        wtbt_n = wt;
        dout_n = 1'b0;
        tick;
        tick;
        chk({tag, "_rply_early"}, 16'(rply_n), 16'h0001);
        tick;
        chk({tag, "_rply"}, 16'(rply_n), 16'h0000);
        tick;
        chk({tag, "_rply_hold"}, 16'(rply_n), 16'h0000);
        dout_n = 1'b1;
        wtbt_n = 1'b1;
        tick;
        chk({tag, "_rply_off"}, 16'(rply_n), 16'h0001);
    endtask

    initial begin
        reset  = 1'b1;
        init_n = 1'b1;
        sync_n = 1'b1;
        din_n  = 1'b1;
        dout_n = 1'b1;
        wtbt_n = 1'b1;
        tb_oe  = 1'b1;
        tb_ad  = 16'h0000;
        tick;
        tick;
        chk("rst_rply", 16'(rply_n), 16'h0001);
        chk("rst_sel", 16'(sel), 16'h0000);
        chk("rst_ad", ad, 16'h0000);
        reset = 1'b0;
        tick;

        // 1: DATO then DATI of a full word
        bus_start(16'h0100);
        chk("t1_sel", 16'(sel), 16'h0001);
        do_write("t1_wr", 16'hBEEF, 1'b1);
        bus_end("t1_wr");
        bus_start(16'h0100);
        do_read("t1_rd", 16'hBEEF);
        bus_end("t1_rd");

        // 2: byte writes to the high lane (odd address) and the low lane (even address)
        bus_start(16'h0101);
        do_write("t2_wb_hi", 16'h3412, 1'b0);
        bus_end("t2_wb_hi");
        bus_start(16'h0101);
        do_read("t2_rd_hi", 16'h12EF);
        bus_end("t2_rd_hi");
        bus_start(16'h0102);
        do_write("t2_wr", 16'hA5C3, 1'b1);
        bus_end("t2_wr");
        bus_start(16'h0102);
        do_write("t2_wb_lo", 16'h997E, 1'b0);
        bus_end("t2_wb_lo");
        bus_start(16'h0102);
        do_read("t2_rd_lo", 16'hA57E);
        bus_end("t2_rd_lo");

        // 3: out-of-window read; the bench keeps ad at 0, so any DUT drive is visible
        bus_start(16'h0800);
        chk("t3_sel", 16'(sel), 16'h0000);
        tb_ad = 16'h0000;
        din_n = 1'b0;
        repeat (4) tick;
        chk("t3_rply", 16'(rply_n), 16'h0001);
        chk("t3_ad", ad, 16'h0000);
        chk("t3_sel_late", 16'(sel), 16'h0000);
        din_n = 1'b1;
        bus_end("t3");

        // 4: DATIO with sync held across the read and the write
        bus_start(16'h0100);
        do_read("t4_rd", 16'h12EF);
        do_write("t4_wr", 16'h5555, 1'b1);
        bus_end("t4");
        bus_start(16'h0100);
        do_read("t4_rb", 16'h5555);
        bus_end("t4_rb");

        // 5a: master releases sync during RWAIT
        bus_start(16'h0100);
        tb_oe = 1'b0;
        din_n = 1'b0;
        tick;
        sync_n = 1'b1;
        din_n  = 1'b1;
        tb_oe  = 1'b1;
        tb_ad  = 16'h0000;
        tick;
        chk("t5_abort_sel", 16'(sel), 16'h0000);
        chk("t5_abort_rply", 16'(rply_n), 16'h0001);
        tick;
        tick;
        chk("t5_abort_rply_late", 16'(rply_n), 16'h0001);
        chk("t5_abort_ad", ad, 16'h0000);

        // 5b: INIT during RDRV
        bus_start(16'h0100);
        tb_oe = 1'b0;
        din_n = 1'b0;
        tick;
        tick;
        tick;
        chk("t5_init_rply_pre", 16'(rply_n), 16'h0000);
        chk("t5_init_data", ad, 16'h5555);
        init_n = 1'b0;
        tb_oe  = 1'b1;
        tb_ad  = 16'h0000;
        tick;
        chk("t5_init_rply", 16'(rply_n), 16'h0001);
        chk("t5_init_ad", ad, 16'h0000);
        chk("t5_init_sel", 16'(sel), 16'h0000);
        init_n = 1'b1;
        din_n  = 1'b1;
        sync_n = 1'b1;
        tick;
        tick;

        // back-to-back read after the aborts: RAM must be intact
        bus_start(16'h0100);
        do_read("t5_rb", 16'h5555);
        bus_end("t5_rb");

`ifdef QMEM_WPROT_EN
        // 6: a protected write is still acknowledged but not stored
        wprot = 1'b1;
        bus_start(16'h0100);
        do_write("t6_wr", 16'h0000, 1'b1);
        bus_end("t6_wr");
        wprot = 1'b0;
        bus_start(16'h0100);
        do_read("t6_rb", 16'h5555);
        bus_end("t6_rb");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
